sum_accumulator: RTL and testbench



---
 rtl/sum_acc_pkg.sv | 12 +
 rtl/sum_accumulator_if.sv | 27 ++
 rtl/acc_add.sv | 25 ++
 rtl/sum_accumulator.sv | 84 ++++++++
 tb/tb_sum_accumulator.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum accumulator.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int SUM_W = 7;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in and total-out valid/ready bundle of the sum accumulator.
interface sum_accumulator_if
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 12
);

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-2:0] S;
    logic             Cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] ACC;
    logic             ovf;

    modport slave (
        input  in_valid, S, Cout, out_ready,
        output in_ready, out_valid, ACC, ovf
    );

    modport master (
        output in_valid, S, Cout, out_ready,
        input  in_ready, out_valid, ACC, ovf
    );

endinterface

// File: rtl/acc_add.sv
// Next-ACC adder; ACC_SATURATE_EN clamps to all-ones on carry, else wraps.
module acc_add
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] sample,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0] sum;

    assign sum   = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, sample};
    assign carry = sum[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, further adds carry again (or add zero), so it stays clamped.
    assign acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator of adder results; optional ACC_SATURATE_EN clamps on overflow.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    sum_accumulator_if.slave    bus
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             carry;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             last;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign accept    = bus.in_valid & in_ready;
    assign last      = (cnt_q == CNT_W'(N_SAMPLES - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.ACC       = acc_q;
    assign bus.ovf       = ovf_q;

    acc_add #(
        .ACC_W(ACC_W)
    ) u_acc_add (
        .acc     (acc_q),
        .sample  ({bus.Cout, bus.S}),
        .acc_next(acc_d),
        .carry   (carry)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Totals stay visible after the output handshake until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | carry;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (wrap and saturate builds).
module tb_sum_accumulator;

    logic clk;
    logic rst_n;
    logic start_a;
    logic start_b;
    logic busy_a;
    logic busy_b;

    int passed;
    int total;

    sum_accumulator_if #(.ACC_W(12)) ifa ();
    sum_accumulator_if #(.ACC_W(8))  ifb ();

    sum_accumulator #(
        .N_SAMPLES(4),
        .ACC_W    (12)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start_a),
        .busy (busy_a),
        .bus  (ifa)
    );

    sum_accumulator #(
        .N_SAMPLES(3),
        .ACC_W    (8)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start_b),
        .busy (busy_b),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a_frame();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic push_a(input logic [5:0] s, input logic c);
        ifa.in_valid = 1'b1;
        ifa.S        = s;
        ifa.Cout     = c;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    task automatic handshake_a();
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (ifa.ACC !== 12'd0) $display("FAIL reset_acc got %0d want 0", ifa.ACC);
        else passed++;
        total++;
        if (ifa.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ifa.ovf);
        else passed++;
        total++;
        if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL reset_flags got %b%b%b want 000",
                     ifa.in_ready, ifa.out_valid, busy_a);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_a_frame();
        total++;
        if (ifa.in_ready !== 1'b1) $display("FAIL basic_in_ready got %b want 1", ifa.in_ready);
        else passed++;
        push_a(6'b011100, 1'b0);
        total++;
        if (ifa.ACC !== 12'd28) $display("FAIL basic_first_acc got %0d want 28", ifa.ACC);
        else passed++;
        push_a(6'b001011, 1'b1);
        push_a(6'b011100, 1'b0);
        total++;
        if (ifa.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", ifa.out_valid);
        else passed++;
        push_a(6'b001011, 1'b1);
        total++;
        if (ifa.out_valid !== 1'b1) $display("FAIL basic_out_valid got %b want 1", ifa.out_valid);
        else passed++;
        total++;
        if (ifa.ACC !== 12'd206) $display("FAIL basic_acc got %0d want 206", ifa.ACC);
        else passed++;
        total++;
        if (ifa.ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ifa.ovf);
        else passed++;
    endtask

    task automatic test_hold();
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.ACC !== 12'd206 || ifa.ovf !== 1'b0)
                $display("FAIL hold_cycle%0d got v=%b acc=%0d ovf=%b want v=1 acc=206 ovf=0",
                         i, ifa.out_valid, ifa.ACC, ifa.ovf);
            else passed++;
        end
        handshake_a();
        total++;
        if (busy_a !== 1'b0 || ifa.out_valid !== 1'b0)
            $display("FAIL hold_release got busy=%b v=%b want 0 0", busy_a, ifa.out_valid);
        else passed++;
        total++;
        if (ifa.ACC !== 12'd206) $display("FAIL hold_acc_idle got %0d want 206", ifa.ACC);
        else passed++;
    endtask

    task automatic test_gaps();
        logic [6:0] samp [4];
        int cyc;
        int accepts;
        logic ph;
        samp[0] = 7'd28;
        samp[1] = 7'd75;
        samp[2] = 7'd28;
        samp[3] = 7'd75;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 1;
        accepts = 0;
        ph = 1'b0;
        while (!ifa.out_valid && cyc < 40) begin
            ifa.in_valid = ph;
            ifa.S        = samp[accepts % 4][5:0];
            ifa.Cout     = samp[accepts % 4][6];
            if (ifa.in_valid && ifa.in_ready) accepts++;
            tick();
            cyc++;
            ph = ~ph;
        end
        ifa.in_valid = 1'b0;
        total++;
        if (ifa.out_valid !== 1'b1) $display("FAIL gaps_timeout got v=%b want 1", ifa.out_valid);
        else passed++;
        total++;
        if (accepts != 4) $display("FAIL gaps_accepts got %0d want 4", accepts);
        else passed++;
        total++;
        if (ifa.ACC !== 12'd206) $display("FAIL gaps_acc got %0d want 206", ifa.ACC);
        else passed++;
        handshake_a();
        cyc++;
        total++;
        if (cyc != 10) $display("FAIL gaps_frame_len got %0d want 10", cyc);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_acc;
`ifdef ACC_SATURATE_EN
        exp_acc = 8'd255;
`else
        exp_acc = 8'd125;
`endif
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ifb.in_valid = 1'b1;
        ifb.S        = 6'h3F;
        ifb.Cout     = 1'b1;
        tick();
        tick();
        total++;
        if (ifb.ovf !== 1'b0 || ifb.ACC !== 8'd254)
            $display("FAIL ovf_pre got acc=%0d ovf=%b want 254 0", ifb.ACC, ifb.ovf);
        else passed++;
        tick();
        ifb.in_valid = 1'b0;
        total++;
        if (ifb.out_valid !== 1'b1) $display("FAIL ovf_valid got %b want 1", ifb.out_valid);
        else passed++;
        total++;
        if (ifb.ACC !== exp_acc) $display("FAIL ovf_acc got %0d want %0d", ifb.ACC, exp_acc);
        else passed++;
        total++;
        if (ifb.ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ifb.ovf);
        else passed++;
        ifb.out_ready = 1'b1;
        tick();
        ifb.out_ready = 1'b0;
        total++;
        if (busy_b !== 1'b0 || ifb.ovf !== 1'b1)
            $display("FAIL ovf_idle got busy=%b ovf=%b want 0 1", busy_b, ifb.ovf);
        else passed++;
    endtask

    task automatic test_reset_mid();
        start_a_frame();
        push_a(6'b011100, 1'b0);
        push_a(6'b001011, 1'b1);
        total++;
        if (ifa.ACC !== 12'd103) $display("FAIL rstmid_pre got %0d want 103", ifa.ACC);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ifa.ACC !== 12'd0 || ifa.ovf !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b0)
            $display("FAIL rstmid_clear got acc=%0d ovf=%b rdy=%b v=%b want 0 0 0 0",
                     ifa.ACC, ifa.ovf, ifa.in_ready, ifa.out_valid);
        else passed++;
        total++;
        if (ifb.ovf !== 1'b0) $display("FAIL rstmid_b_ovf got %b want 0", ifb.ovf);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        start_a_frame();
        push_a(6'b011100, 1'b0);
        push_a(6'b001011, 1'b1);
        push_a(6'b011100, 1'b0);
        push_a(6'b001011, 1'b1);
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.ACC !== 12'd206)
            $display("FAIL rstmid_fresh got v=%b acc=%0d want 1 206", ifa.out_valid, ifa.ACC);
        else passed++;
        handshake_a();
    endtask

    task automatic test_ignore();
        ifa.in_valid = 1'b1;
        ifa.S        = 6'h3F;
        ifa.Cout     = 1'b1;
        tick();
        tick();
        ifa.in_valid = 1'b0;
        total++;
        if (busy_a !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.ACC !== 12'd206)
            $display("FAIL ign_idle got busy=%b rdy=%b acc=%0d want 0 0 206",
                     busy_a, ifa.in_ready, ifa.ACC);
        else passed++;
        start_a_frame();
        push_a(6'b011100, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        total++;
        if (ifa.in_ready !== 1'b1 || ifa.ACC !== 12'd28)
            $display("FAIL ign_accum got rdy=%b acc=%0d want 1 28", ifa.in_ready, ifa.ACC);
        else passed++;
        push_a(6'b001011, 1'b1);
        push_a(6'b011100, 1'b0);
        push_a(6'b001011, 1'b1);
        start_a = 1'b1;
        tick();
        tick();
        start_a = 1'b0;
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.ACC !== 12'd206)
            $display("FAIL ign_done got v=%b acc=%0d want 1 206", ifa.out_valid, ifa.ACC);
        else passed++;
        handshake_a();
        total++;
        if (busy_a !== 1'b0) $display("FAIL ign_final_busy got %b want 0", busy_a);
        else passed++;
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst_n         = 1'b1;
        start_a       = 1'b0;
        start_b       = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.S         = '0;
        ifa.Cout      = 1'b0;
        ifa.out_ready = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.S         = '0;
        ifb.Cout      = 1'b0;
        ifb.out_ready = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_hold();
        test_gaps();
        test_overflow();
        test_reset_mid();
        test_ignore();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
